// File: rtl/irq_pending_ctrl.sv
// Captures rising edges on eight interrupt lines into a pending register, feeds the
// masked vector to an external priority encoder, and serves one held request at a time.
module irq_pending_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] irq,
    input  logic [7:0] mask,
    input  logic       en,
    input  logic [2:0] enc_o,
    input  logic       enc_v,
    input  logic       ack,
    input  logic       ovf_clr,
    output logic [7:0] d,
    output logic       En,
    output logic       irq_req,
    output logic [2:0] irq_id,
    output logic [7:0] pending,
    output logic [7:0] ovf
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_CLR  = 2'd2
    } state_t;

    state_t     r_state;
    logic [7:0] r_pending;
    logic [7:0] r_irq_prev;
    logic [7:0] r_ovf;
    logic       r_irq_req;
    logic [2:0] r_irq_id;

    logic       w_ack_req;
    logic [7:0] w_edge;
    logic [7:0] w_ack_clr;
    logic [7:0] w_pending_next;
    logic [7:0] w_ovf_next;

    assign w_ack_req = (r_state == S_REQ) && ack;

    // A fresh edge beats the acknowledge clear, and is then not counted as an overflow.
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_line
            assign w_edge[gi]         = irq[gi] & ~r_irq_prev[gi];
            assign w_ack_clr[gi]      = w_ack_req && (r_irq_id == 3'(gi));
            assign w_pending_next[gi] = w_edge[gi] | (r_pending[gi] & ~w_ack_clr[gi]);
            assign w_ovf_next[gi]     = (w_edge[gi] & r_pending[gi] & ~w_ack_clr[gi])
                                      | (r_ovf[gi] & ~ovf_clr);
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pending  <= 8'h00;
            r_irq_prev <= 8'h00;
            r_ovf      <= 8'h00;
        end else begin
            r_pending  <= w_pending_next;
            r_irq_prev <= irq;
            r_ovf      <= w_ovf_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_irq_req <= 1'b0;
            r_irq_id  <= 3'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (en && enc_v) begin
                        r_irq_id  <= enc_o;
                        r_irq_req <= 1'b1;
                        r_state   <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (ack) begin
                        r_irq_req <= 1'b0;
                        r_state   <= S_CLR;
                    end
                end
                S_CLR: begin
                    r_irq_req <= 1'b0;
                    r_state   <= S_IDLE;
                end
                default: begin
                    r_irq_req <= 1'b0;
                    r_state   <= S_IDLE;
                end
            endcase
        end
    end

    assign d       = r_pending & ~mask;
    assign En      = en;
    assign irq_req = r_irq_req;
    assign irq_id  = r_irq_id;
    assign pending = r_pending;
    assign ovf     = r_ovf;

endmodule
